// File: rtl/f32_addsub_arbiter_if.sv
// Request/response bundle between the two requesters and the shared F32 add/sub arbiter.
// The master side drives requests and takes responses; the slave side is the arbiter.
interface f32_addsub_arbiter_if;
    logic        REQ0_VALID;
    logic        REQ0_READY;
    logic [31:0] REQ0_A;
    logic [31:0] REQ0_B;
    logic        REQ0_OP;
    logic        REQ1_VALID;
    logic        REQ1_READY;
    logic [31:0] REQ1_A;
    logic [31:0] REQ1_B;
    logic        REQ1_OP;
    logic        RSP0_VALID;
    logic        RSP0_READY;
    logic        RSP1_VALID;
    logic        RSP1_READY;
    logic [31:0] RSP_R;
    logic        RSP_UNDERFLOW;
    logic        RSP_OVERFLOW;

    modport master (
        output REQ0_VALID, REQ0_A, REQ0_B, REQ0_OP,
        output REQ1_VALID, REQ1_A, REQ1_B, REQ1_OP,
        output RSP0_READY, RSP1_READY,
        input  REQ0_READY, REQ1_READY,
        input  RSP0_VALID, RSP1_VALID, RSP_R, RSP_UNDERFLOW, RSP_OVERFLOW
    );

    modport slave (
        input  REQ0_VALID, REQ0_A, REQ0_B, REQ0_OP,
        input  REQ1_VALID, REQ1_A, REQ1_B, REQ1_OP,
        input  RSP0_READY, RSP1_READY,
        output REQ0_READY, REQ1_READY,
        output RSP0_VALID, RSP1_VALID, RSP_R, RSP_UNDERFLOW, RSP_OVERFLOW
    );
endinterface

// File: rtl/f32_addsub_arbiter.sv
// Round-robin arbiter sharing one combinational F32 add/sub between two requesters.
// Optional sticky flag outputs are enabled with `define F32_ARB_STICKY_FLAGS_EN.
module f32_addsub_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    f32_addsub_arbiter_if.slave  bus,
    output logic [31:0]          ADD_A,
    output logic [31:0]          ADD_B,
    output logic                 ADD_OP,
    input  logic [31:0]          ADD_R,
    input  logic                 ADD_UNDERFLOW,
    input  logic                 ADD_OVERFLOW,
    output logic                 BUSY
`ifdef F32_ARB_STICKY_FLAGS_EN
    ,
    input  logic                 CLR_STICKY,
    output logic                 STICKY_UNDERFLOW,
    output logic                 STICKY_OVERFLOW
`endif
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        g_q, g_d;
    logic        last_q, last_d;
    logic        rsp0_vld_q, rsp0_vld_d;
    logic        rsp1_vld_q, rsp1_vld_d;
    logic [31:0] add_a_q, add_a_d;
    logic [31:0] add_b_q, add_b_d;
    logic        add_op_q, add_op_d;
    logic [31:0] rsp_r_q, rsp_r_d;
    logic        rsp_uf_q, rsp_uf_d;
    logic        rsp_of_q, rsp_of_d;
    logic        sel;
    logic        req_hs;
    logic        rsp_rdy_g;

    // Contention goes to whoever was not served last.
    always_comb begin
        sel = ~last_q;
        if (bus.REQ0_VALID && !bus.REQ1_VALID) begin
            sel = 1'b0;
        end else if (bus.REQ1_VALID && !bus.REQ0_VALID) begin
            sel = 1'b1;
        end
    end

    assign bus.REQ0_READY = (state_q == IDLE) && bus.REQ0_VALID && !sel;
    assign bus.REQ1_READY = (state_q == IDLE) && bus.REQ1_VALID && sel;
    assign req_hs         = bus.REQ0_READY || bus.REQ1_READY;
    assign rsp_rdy_g      = g_q ? bus.RSP1_READY : bus.RSP0_READY;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        g_d        = g_q;
        last_d     = last_q;
        rsp0_vld_d = rsp0_vld_q;
        rsp1_vld_d = rsp1_vld_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        add_op_d   = add_op_q;
        rsp_r_d    = rsp_r_q;
        rsp_uf_d   = rsp_uf_q;
        rsp_of_d   = rsp_of_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    add_a_d  = sel ? bus.REQ1_A  : bus.REQ0_A;
                    add_b_d  = sel ? bus.REQ1_B  : bus.REQ0_B;
                    add_op_d = sel ? bus.REQ1_OP : bus.REQ0_OP;
                    g_d      = sel;
                    cnt_d    = SETTLE_INIT;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_r_d    = ADD_R;
                    rsp_uf_d   = ADD_UNDERFLOW;
                    rsp_of_d   = ADD_OVERFLOW;
                    rsp0_vld_d = ~g_q;
                    rsp1_vld_d = g_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (rsp_rdy_g) begin
                    rsp0_vld_d = 1'b0;
                    rsp1_vld_d = 1'b0;
                    last_d     = g_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset clears everything, including operands and the captured result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            g_q        <= 1'b0;
            last_q     <= 1'b1;
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            add_a_q    <= 32'd0;
            add_b_q    <= 32'd0;
            add_op_q   <= 1'b0;
            rsp_r_q    <= 32'd0;
            rsp_uf_q   <= 1'b0;
            rsp_of_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            g_q        <= g_d;
            last_q     <= last_d;
            rsp0_vld_q <= rsp0_vld_d;
            rsp1_vld_q <= rsp1_vld_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_op_q   <= add_op_d;
            rsp_r_q    <= rsp_r_d;
            rsp_uf_q   <= rsp_uf_d;
            rsp_of_q   <= rsp_of_d;
        end
    end

    assign ADD_A             = add_a_q;
    assign ADD_B             = add_b_q;
    assign ADD_OP            = add_op_q;
    assign bus.RSP0_VALID    = rsp0_vld_q;
    assign bus.RSP1_VALID    = rsp1_vld_q;
    assign bus.RSP_R         = rsp_r_q;
    assign bus.RSP_UNDERFLOW = rsp_uf_q;
    assign bus.RSP_OVERFLOW  = rsp_of_q;
    assign BUSY              = (state_q != IDLE);

`ifdef F32_ARB_STICKY_FLAGS_EN
    logic capture;
    logic sticky_uf_q, sticky_uf_d;
    logic sticky_of_q, sticky_of_d;

    // A flag captured in the same cycle as a clear request still sets.
    assign capture = (state_q == SETTLE) && (cnt_q == 4'd1);

    always_comb begin
        sticky_uf_d = sticky_uf_q;
        sticky_of_d = sticky_of_q;
        if (capture && ADD_UNDERFLOW) begin
            sticky_uf_d = 1'b1;
        end else if (CLR_STICKY) begin
            sticky_uf_d = 1'b0;
        end
        if (capture && ADD_OVERFLOW) begin
            sticky_of_d = 1'b1;
        end else if (CLR_STICKY) begin
            sticky_of_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sticky_uf_q <= 1'b0;
            sticky_of_q <= 1'b0;
        end else begin
            sticky_uf_q <= sticky_uf_d;
            sticky_of_q <= sticky_of_d;
        end
    end

    assign STICKY_UNDERFLOW = sticky_uf_q;
    assign STICKY_OVERFLOW  = sticky_of_q;
`endif

endmodule

// File: tb/tb_f32_addsub_arbiter.sv
// Bench for f32_addsub_arbiter: transaction-level model checked every cycle plus directed literals.
module tb_f32_addsub_arbiter;
    localparam int S = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    f32_addsub_arbiter_if bus();
    f32_addsub_arbiter_if if_s1();
    f32_addsub_arbiter_if if_s15();

    logic [31:0] add_a, add_b, add_r;
    logic        add_op, busy;
    logic        stub_uf = 1'b0, stub_of = 1'b0;
    logic [31:0] s1_a, s1_b, s15_a, s15_b;
    logic        s1_op, s15_op, s1_busy, s15_busy;
    logic        aux_v = 1'b0;
`ifdef F32_ARB_STICKY_FLAGS_EN
    logic clr_sticky = 1'b0;
    logic sticky_uf, sticky_of, s1_suf, s1_sof, s15_suf, s15_sof;
`endif

    int n_vec = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic real f2r(input logic [31:0] x);
        int  e;
        real m;
        e = int'(x[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] f32_add(input logic [31:0] a, input logic [31:0] b, input logic op);
        return r2f(op ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b)));
    endfunction

    // Bench-side adder attached to the main DUT; flags come from the stub controls.
    assign add_r = f32_add(add_a, add_b, add_op);

    f32_addsub_arbiter #(.SETTLE_CYCLES(S)) dut (
        .CLK(CLK), .RST(RST), .bus(bus),
        .ADD_A(add_a), .ADD_B(add_b), .ADD_OP(add_op),
        .ADD_R(add_r), .ADD_UNDERFLOW(stub_uf), .ADD_OVERFLOW(stub_of),
        .BUSY(busy)
`ifdef F32_ARB_STICKY_FLAGS_EN
        , .CLR_STICKY(clr_sticky), .STICKY_UNDERFLOW(sticky_uf), .STICKY_OVERFLOW(sticky_of)
`endif
    );

    f32_addsub_arbiter #(.SETTLE_CYCLES(1)) dut_s1 (
        .CLK(CLK), .RST(RST), .bus(if_s1),
        .ADD_A(s1_a), .ADD_B(s1_b), .ADD_OP(s1_op),
        .ADD_R(32'h0), .ADD_UNDERFLOW(1'b0), .ADD_OVERFLOW(1'b0),
        .BUSY(s1_busy)
`ifdef F32_ARB_STICKY_FLAGS_EN
        , .CLR_STICKY(1'b0), .STICKY_UNDERFLOW(s1_suf), .STICKY_OVERFLOW(s1_sof)
`endif
    );

    f32_addsub_arbiter #(.SETTLE_CYCLES(15)) dut_s15 (
        .CLK(CLK), .RST(RST), .bus(if_s15),
        .ADD_A(s15_a), .ADD_B(s15_b), .ADD_OP(s15_op),
        .ADD_R(32'h0), .ADD_UNDERFLOW(1'b0), .ADD_OVERFLOW(1'b0),
        .BUSY(s15_busy)
`ifdef F32_ARB_STICKY_FLAGS_EN
        , .CLR_STICKY(1'b0), .STICKY_UNDERFLOW(s15_suf), .STICKY_OVERFLOW(s15_sof)
`endif
    );

    assign if_s1.REQ0_VALID  = aux_v;
    assign if_s1.REQ0_A      = 32'h3F800000;
    assign if_s1.REQ0_B      = 32'h3F800000;
    assign if_s1.REQ0_OP     = 1'b0;
    assign if_s1.REQ1_VALID  = 1'b0;
    assign if_s1.REQ1_A      = 32'h0;
    assign if_s1.REQ1_B      = 32'h0;
    assign if_s1.REQ1_OP     = 1'b0;
    assign if_s1.RSP0_READY  = 1'b1;
    assign if_s1.RSP1_READY  = 1'b1;
    assign if_s15.REQ0_VALID = aux_v;
    assign if_s15.REQ0_A     = 32'h3F800000;
    assign if_s15.REQ0_B     = 32'h3F800000;
    assign if_s15.REQ0_OP    = 1'b0;
    assign if_s15.REQ1_VALID = 1'b0;
    assign if_s15.REQ1_A     = 32'h0;
    assign if_s15.REQ1_B     = 32'h0;
    assign if_s15.REQ1_OP    = 1'b0;
    assign if_s15.RSP0_READY = 1'b1;
    assign if_s15.RSP1_READY = 1'b1;

    // Transaction model: one operation in flight, response due S edges after acceptance.
    int          cyc = 0;
    int          m_hs = 0;
    bit          m_active = 0, m_capt = 0, m_g = 0, m_last = 1;
    logic [31:0] m_a = 0, m_b = 0, m_r = 0;
    bit          m_op = 0, m_uf = 0, m_of = 0, m_suf = 0, m_sof = 0;
    bit          cmp_en = 0;

    always @(posedge CLK) begin
        bit cap, gsel;
        cyc++;
        cap = 0;
        if (RST) begin
            m_active = 0; m_capt = 0; m_g = 0; m_last = 1;
            m_a = 0; m_b = 0; m_op = 0; m_r = 0; m_uf = 0; m_of = 0;
            m_suf = 0; m_sof = 0;
        end else begin
            if (!m_active) begin
                if (bus.REQ0_VALID || bus.REQ1_VALID) begin
                    gsel = (bus.REQ0_VALID && bus.REQ1_VALID) ? !m_last : bus.REQ1_VALID;
                    m_active = 1; m_capt = 0; m_g = gsel; m_hs = cyc;
                    m_a  = gsel ? bus.REQ1_A  : bus.REQ0_A;
                    m_b  = gsel ? bus.REQ1_B  : bus.REQ0_B;
                    m_op = gsel ? bus.REQ1_OP : bus.REQ0_OP;
                end
            end else if (!m_capt) begin
                if (cyc == m_hs + S) begin
                    m_r = f32_add(m_a, m_b, m_op);
                    m_uf = stub_uf; m_of = stub_of;
                    m_capt = 1; cap = 1;
                end
            end else if (m_g ? bus.RSP1_READY : bus.RSP0_READY) begin
                m_active = 0; m_capt = 0; m_last = m_g;
            end
`ifdef F32_ARB_STICKY_FLAGS_EN
            if (cap && stub_uf) m_suf = 1; else if (clr_sticky) m_suf = 0;
            if (cap && stub_of) m_sof = 1; else if (clr_sticky) m_sof = 0;
`endif
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("m_rdy0", bus.REQ0_READY, !m_active && bus.REQ0_VALID && (!bus.REQ1_VALID || m_last));
            chk("m_rdy1", bus.REQ1_READY, !m_active && bus.REQ1_VALID && (!bus.REQ0_VALID || !m_last));
            chk("m_rsp0_vld", bus.RSP0_VALID, m_active && m_capt && !m_g);
            chk("m_rsp1_vld", bus.RSP1_VALID, m_active && m_capt && m_g);
            chk("m_rsp_r", bus.RSP_R, m_r);
            chk("m_rsp_uf", bus.RSP_UNDERFLOW, m_uf);
            chk("m_rsp_of", bus.RSP_OVERFLOW, m_of);
            chk("m_add_a", add_a, m_a);
            chk("m_add_b", add_b, m_b);
            chk("m_add_op", add_op, m_op);
            chk("m_busy", busy, m_active);
`ifdef F32_ARB_STICKY_FLAGS_EN
            chk("m_sticky_uf", sticky_uf, m_suf);
            chk("m_sticky_of", sticky_of, m_sof);
`endif
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
    endtask

    task automatic wait_rsp(input bit n, input int bound);
        bit ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK);
            if (n ? bus.RSP1_VALID : bus.RSP0_VALID) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("rsp_timeout", n ? bus.RSP1_VALID : bus.RSP0_VALID, 1);
    endtask

    task automatic wait_idle(input int bound);
        bit ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", busy, 0);
    endtask

    task automatic run_op(input bit n, input logic [31:0] a, input logic [31:0] b, input bit op,
                          output logic [31:0] r, output logic uf, output logic of);
        bit ok = 0;
        tick();
        if (n) begin
            bus.REQ1_VALID = 1; bus.REQ1_A = a; bus.REQ1_B = b; bus.REQ1_OP = op;
        end else begin
            bus.REQ0_VALID = 1; bus.REQ0_A = a; bus.REQ0_B = b; bus.REQ0_OP = op;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (n ? bus.REQ1_READY : bus.REQ0_READY) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("rdy_timeout", n ? bus.REQ1_READY : bus.REQ0_READY, 1);
        tick();
        bus.REQ0_VALID = 0; bus.REQ1_VALID = 0;
        wait_rsp(n, 40);
        r = bus.RSP_R; uf = bus.RSP_UNDERFLOW; of = bus.RSP_OVERFLOW;
        tick();
        if (n) bus.RSP1_READY = 1; else bus.RSP0_READY = 1;
        wait_idle(20);
        tick();
        bus.RSP0_READY = 0; bus.RSP1_READY = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, r0, r1;
        logic        uf, of;
        int          gseq[4];
        int          ng, lat1, lat15;

        bus.REQ0_VALID = 0; bus.REQ0_A = 0; bus.REQ0_B = 0; bus.REQ0_OP = 0;
        bus.REQ1_VALID = 0; bus.REQ1_A = 0; bus.REQ1_B = 0; bus.REQ1_OP = 0;
        bus.RSP0_READY = 0; bus.RSP1_READY = 0;

        do_reset();
        cmp_en = 1;
        @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_rsp_r", bus.RSP_R, 32'h0);
        chk("rst_rsp0_vld", bus.RSP0_VALID, 0);

        // Single add 1.0 + 2.0
        tick();
        bus.REQ0_VALID = 1; bus.REQ0_A = 32'h3F800000; bus.REQ0_B = 32'h40000000; bus.REQ0_OP = 0;
        @(negedge CLK);
        chk("t1_rdy0", bus.REQ0_READY, 1);
        chk("t1_rdy1", bus.REQ1_READY, 0);
        tick();
        bus.REQ0_VALID = 0;
        @(negedge CLK);
        chk("t1_add_a", add_a, 32'h3F800000);
        chk("t1_add_b", add_b, 32'h40000000);
        chk("t1_busy", busy, 1);
        tick();
        @(negedge CLK);
        chk("t1_rsp0_early", bus.RSP0_VALID, 0);
        tick();
        @(negedge CLK);
        chk("t1_rsp0_vld", bus.RSP0_VALID, 1);
        chk("t1_rsp_r", bus.RSP_R, 32'h40400000);
        chk("t1_rsp_of", bus.RSP_OVERFLOW, 0);
        chk("t1_rsp1_vld", bus.RSP1_VALID, 0);
        tick();
        bus.RSP0_READY = 1;
        tick();
        bus.RSP0_READY = 0;
        @(negedge CLK);
        chk("t1_busy_end", busy, 0);

        // Contention from reset with responses always accepted
        do_reset();
        bus.REQ0_VALID = 1; bus.REQ0_A = 32'h40A00000; bus.REQ0_B = 32'h3F800000; bus.REQ0_OP = 1;
        bus.REQ1_VALID = 1; bus.REQ1_A = 32'h3F800000; bus.REQ1_B = 32'h3F800000; bus.REQ1_OP = 0;
        bus.RSP0_READY = 1; bus.RSP1_READY = 1;
        gseq = '{default: 2};
        ng = 0; r0 = 32'hDEADBEEF; r1 = 32'hDEADBEEF;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (ng < 4 && bus.REQ0_READY) begin gseq[ng] = 0; ng++; end
            else if (ng < 4 && bus.REQ1_READY) begin gseq[ng] = 1; ng++; end
            if (bus.RSP0_VALID) r0 = bus.RSP_R;
            if (bus.RSP1_VALID) r1 = bus.RSP_R;
        end
        chk("t2_grant0", gseq[0], 0);
        chk("t2_grant1", gseq[1], 1);
        chk("t2_grant2", gseq[2], 0);
        chk("t2_grant3", gseq[3], 1);
        chk("t2_r0", r0, 32'h40800000);
        chk("t2_r1", r1, 32'h40000000);
        tick();
        bus.REQ0_VALID = 0; bus.REQ1_VALID = 0;
        wait_idle(20);
        tick();
        bus.RSP0_READY = 0; bus.RSP1_READY = 0;

        // Back-pressure on requester 0 while requester 1 waits
        tick();
        bus.REQ0_VALID = 1; bus.REQ0_A = 32'h40400000; bus.REQ0_B = 32'h40000000; bus.REQ0_OP = 0;
        @(negedge CLK);
        chk("t3_rdy0", bus.REQ0_READY, 1);
        tick();
        bus.REQ0_VALID = 0;
        bus.REQ1_VALID = 1; bus.REQ1_A = 32'h40800000; bus.REQ1_B = 32'h3F800000; bus.REQ1_OP = 1;
        wait_rsp(0, 20);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge CLK);
            chk("t3_hold_vld", bus.RSP0_VALID, 1);
            chk("t3_hold_r", bus.RSP_R, 32'h40A00000);
            chk("t3_hold_busy", busy, 1);
            chk("t3_hold_rdy1", bus.REQ1_READY, 0);
        end
        tick();
        bus.RSP0_READY = 1;
        @(negedge CLK);
        chk("t3_rdy1_pre", bus.REQ1_READY, 0);
        tick();
        bus.RSP0_READY = 0;
        @(negedge CLK);
        chk("t3_rdy1_post", bus.REQ1_READY, 1);
        tick();
        bus.REQ1_VALID = 0;
        wait_rsp(1, 20);
        chk("t3_r1", bus.RSP_R, 32'h40400000);
        bus.RSP1_READY = 1;
        wait_idle(20);
        tick();
        bus.RSP1_READY = 0;

        // Reset during SETTLE aborts the op and restores round-robin priority
        run_op(0, 32'h3F800000, 32'h3F800000, 0, r, uf, of);
        tick();
        bus.REQ1_VALID = 1; bus.REQ1_A = 32'h40000000; bus.REQ1_B = 32'h40000000; bus.REQ1_OP = 0;
        @(negedge CLK);
        chk("t4_rdy1", bus.REQ1_READY, 1);
        tick();
        bus.REQ1_VALID = 0;
        tick();
        RST = 1;
        tick();
        RST = 0;
        @(negedge CLK);
        chk("t4_busy", busy, 0);
        chk("t4_add_a", add_a, 32'h0);
        chk("t4_rsp_r", bus.RSP_R, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge CLK);
            chk("t4_no_rsp1", bus.RSP1_VALID, 0);
        end
        tick();
        bus.REQ0_VALID = 1; bus.REQ1_VALID = 1;
        @(negedge CLK);
        chk("t4_rdy0", bus.REQ0_READY, 1);
        chk("t4_rdy1", bus.REQ1_READY, 0);
        tick();
        bus.REQ0_VALID = 0; bus.REQ1_VALID = 0; bus.RSP0_READY = 1;
        wait_idle(20);
        tick();
        bus.RSP0_READY = 0;

        // Flags pass through; sticky flags survive a clean op until cleared
        stub_of = 1;
        run_op(0, 32'h3F800000, 32'h40000000, 0, r, uf, of);
        chk("t5_of", of, 1);
        chk("t5_of_uf", uf, 0);
        stub_of = 0; stub_uf = 1;
        run_op(1, 32'h40000000, 32'h3F800000, 1, r, uf, of);
        chk("t5_uf", uf, 1);
        chk("t5_uf_r", r, 32'h3F800000);
        stub_uf = 0;
        run_op(0, 32'h3F800000, 32'h3F800000, 0, r, uf, of);
        chk("t5_clean_of", of, 0);
        chk("t5_clean_r", r, 32'h40000000);
`ifdef F32_ARB_STICKY_FLAGS_EN
        @(negedge CLK);
        chk("t5_sticky_of", sticky_of, 1);
        chk("t5_sticky_uf", sticky_uf, 1);
        tick();
        clr_sticky = 1;
        tick();
        clr_sticky = 0;
        @(negedge CLK);
        chk("t5_sticky_of_clr", sticky_of, 0);
        chk("t5_sticky_uf_clr", sticky_uf, 0);
`endif

        // Handshake-to-response latency for SETTLE_CYCLES = 1 and 15
        tick();
        aux_v = 1;
        @(negedge CLK);
        chk("t6_s1_rdy", if_s1.REQ0_READY, 1);
        chk("t6_s15_rdy", if_s15.REQ0_READY, 1);
        tick();
        aux_v = 0;
        lat1 = 0; lat15 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (lat1 == 0 && if_s1.RSP0_VALID) lat1 = k;
            if (lat15 == 0 && if_s15.RSP0_VALID) lat15 = k;
            if (lat1 != 0 && lat15 != 0) break;
            if (k != 40) tick();
        end
        chk("t6_lat_s1", lat1, 2);
        chk("t6_lat_s15", lat15, 16);

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
